// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: load-use / RAW stall detection, branch flush, operand
// forwarding selects and saturating stall/flush event counters.
module hazard_ctrl #(
  parameter bit FWD_EN    = 1'b1,
  parameter bit RF_BYPASS = 1'b1,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ID_have_inst,
  input  logic [4:0]       ID_rs1,
  input  logic [4:0]       ID_rs2,
  input  logic             ID_re1,
  input  logic             ID_re2,
  input  logic [4:0]       ID_rd,
  input  logic             ID_rf_we,
  input  logic             ID_is_load,
  input  logic             EX_br_taken,
  output logic             pc_stall,
  output logic             IF_ID_stall,
  output logic             ID_EX_stall,
  output logic             IF_ID_flush,
  output logic [1:0]       fwd_rs1_sel,
  output logic [1:0]       fwd_rs2_sel,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef struct packed {
    logic [4:0] rd;
    logic       we;
    logic       load;
  } sh_t;

  typedef enum logic [1:0] {
    SEL_RF  = 2'd0,
    SEL_EX  = 2'd1,
    SEL_MEM = 2'd2,
    SEL_WB  = 2'd3
  } fwd_sel_e;

  sh_t ex_sh_q, ex_sh_d;
  sh_t mem_sh_q, mem_sh_d;
  sh_t wb_sh_q, wb_sh_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic m_ex1, m_mem1, m_wb1;
  logic m_ex2, m_mem2, m_wb2;
  logic hazard;
  logic bubble;

  function automatic logic match(input sh_t sh, input logic re, input logic [4:0] rs,
                                 input logic have);
    return have & re & (rs != 5'd0) & sh.we & (sh.rd == rs);
  endfunction

  function automatic fwd_sel_e pick(input logic ex, input logic mem, input logic wb);
    fwd_sel_e sel;
    sel = SEL_RF;
    if (FWD_EN) begin
      if (ex)                    sel = SEL_EX;
      else if (mem)              sel = SEL_MEM;
      else if (wb && !RF_BYPASS) sel = SEL_WB;
    end
    return sel;
  endfunction

  always_comb begin
    // NOTE: every signal written here is assigned a default first, so no path can infer a latch.
    m_ex1  = match(ex_sh_q,  ID_re1, ID_rs1, ID_have_inst);
    m_mem1 = match(mem_sh_q, ID_re1, ID_rs1, ID_have_inst);
    m_wb1  = match(wb_sh_q,  ID_re1, ID_rs1, ID_have_inst);
    m_ex2  = match(ex_sh_q,  ID_re2, ID_rs2, ID_have_inst);
    m_mem2 = match(mem_sh_q, ID_re2, ID_rs2, ID_have_inst);
    m_wb2  = match(wb_sh_q,  ID_re2, ID_rs2, ID_have_inst);

    hazard = 1'b0;
    if (FWD_EN) begin
      hazard = ex_sh_q.load & (m_ex1 | m_ex2);
    end else begin
      hazard = m_ex1 | m_ex2 | m_mem1 | m_mem2 | (!RF_BYPASS & (m_wb1 | m_wb2));
    end

    // A taken branch wins: the instruction held in ID is wrong-path anyway.
    pc_stall    = hazard & ~EX_br_taken;
    IF_ID_stall = hazard | EX_br_taken;
    ID_EX_stall = hazard | EX_br_taken;
    IF_ID_flush = EX_br_taken;
    bubble      = hazard | EX_br_taken;

    fwd_rs1_sel = pick(m_ex1, m_mem1, m_wb1);
    fwd_rs2_sel = pick(m_ex2, m_mem2, m_wb2);

    ex_sh_d = '0;
    if (!bubble) begin
      ex_sh_d.rd   = ID_rd;
      ex_sh_d.we   = ID_rf_we & ID_have_inst & (ID_rd != 5'd0);
      ex_sh_d.load = ID_is_load;
    end
    mem_sh_d = ex_sh_q;
    wb_sh_d  = mem_sh_q;

    stall_cnt_d = stall_cnt_q;
    if (hazard && !EX_br_taken && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    flush_cnt_d = flush_cnt_q;
    if (EX_br_taken && !(&flush_cnt_q)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of order.
    if (rst) begin
      ex_sh_q     <= '0;
      mem_sh_q    <= '0;
      wb_sh_q     <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ex_sh_q     <= ex_sh_d;
      mem_sh_q    <= mem_sh_d;
      wb_sh_q     <= wb_sh_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule
